// File: rtl/calc_entry_ctrl.sv
// Keypad front end of the calculator: turns one-cycle key events into the
// sign-magnitude operand pair, the opcode and the newop/newhex/eq pulses
// consumed by the arithmetic module, and selects what the display shows.
module calc_entry_ctrl #(
    parameter int MAG_W  = 16,
    parameter int DIGITS = 4,
    parameter int KEY_W  = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             key_valid,
    input  logic [KEY_W-1:0] key_code,
    input  logic [MAG_W:0]   answer,
    input  logic             ovw_in,
    output logic [MAG_W:0]   V1,
    output logic [MAG_W:0]   V2,
    output logic [1:0]       opcode,
    output logic             newop,
    output logic             newhex,
    output logic             eq,
    output logic [MAG_W:0]   disp_value,
    output logic             disp_ovw
);

    typedef enum logic [1:0] {
        ENTRY_A = 2'd0,
        OP_WAIT = 2'd1,
        ENTRY_B = 2'd2,
        RESULT  = 2'd3
    } state_t;

    localparam logic [KEY_W-1:0] K_ADD = KEY_W'(5'h10);
    localparam logic [KEY_W-1:0] K_MUL = KEY_W'(5'h11);
    localparam logic [KEY_W-1:0] K_SUB = KEY_W'(5'h12);
    localparam logic [KEY_W-1:0] K_EQ  = KEY_W'(5'h13);
    localparam logic [KEY_W-1:0] K_CLR = KEY_W'(5'h14);
    localparam logic [KEY_W-1:0] K_NEG = KEY_W'(5'h15);

    state_t           state, state_nxt;
    logic [MAG_W:0]   v1_nxt, v2_nxt;
    logic [1:0]       op_nxt;
    logic             newop_nxt, newhex_nxt, eq_nxt;

    logic             is_digit, is_op, digit_room;
    logic [3:0]       digit;

    // Operator key to arithmetic opcode: 00 add, 01 mul, 10 sub (V2-V1).
    function automatic logic [1:0] map_op(input logic [KEY_W-1:0] k);
        case (k)
            K_MUL:   map_op = 2'b01;
            K_SUB:   map_op = 2'b10;
            default: map_op = 2'b00;
        endcase
    endfunction

    // Append one hex digit at the low end of the magnitude, keeping the sign.
    function automatic logic [MAG_W:0] shift_digit(input logic [MAG_W:0] v,
                                                    input logic [3:0] d);
        shift_digit = {v[MAG_W], v[MAG_W-5:0], d};
    endfunction

    assign is_digit   = (key_code < KEY_W'(16));
    assign is_op      = (key_code == K_ADD) || (key_code == K_MUL) || (key_code == K_SUB);
    assign digit      = key_code[3:0];
    // A new digit only fits while the top hex digit of the entry is still zero.
    assign digit_room = (V1[DIGITS*4-1 -: 4] == 4'd0);

    // Next-state and next-output decode for the sampled key.
    always_comb begin
        state_nxt  = state;
        v1_nxt     = V1;
        v2_nxt     = V2;
        op_nxt     = opcode;
        newop_nxt  = 1'b0;
        newhex_nxt = 1'b0;
        eq_nxt     = 1'b0;
        if (key_valid) begin
            if (key_code == K_CLR) begin
                v1_nxt    = '0;
                v2_nxt    = '0;
                op_nxt    = 2'b00;
                newop_nxt = 1'b1;
                state_nxt = ENTRY_A;
            end else begin
                case (state)
                    ENTRY_A, ENTRY_B: begin
                        if (is_digit && digit_room) begin
                            v1_nxt     = shift_digit(V1, digit);
                            newhex_nxt = 1'b1;
                        end else if (key_code == K_NEG) begin
                            v1_nxt     = {~V1[MAG_W], V1[MAG_W-1:0]};
                            newhex_nxt = 1'b1;
                        end else if (is_op) begin
                            // ENTRY_A starts the chain from the entry; ENTRY_B
                            // folds the pending result into the accumulator.
                            v2_nxt    = (state == ENTRY_A) ? V1 : answer;
                            v1_nxt    = '0;
                            op_nxt    = map_op(key_code);
                            newop_nxt = 1'b1;
                            state_nxt = OP_WAIT;
                        end else if (key_code == K_EQ && state == ENTRY_B) begin
                            eq_nxt    = 1'b1;
                            state_nxt = RESULT;
                        end
                    end
                    OP_WAIT: begin
                        if (is_op) begin
                            // Operator replaced before the second operand: no chaining.
                            op_nxt    = map_op(key_code);
                            newop_nxt = 1'b1;
                        end else if (is_digit && digit_room) begin
                            v1_nxt     = shift_digit(V1, digit);
                            newhex_nxt = 1'b1;
                            state_nxt  = ENTRY_B;
                        end else if (key_code == K_NEG) begin
                            v1_nxt     = {~V1[MAG_W], V1[MAG_W-1:0]};
                            newhex_nxt = 1'b1;
                        end
                    end
                    RESULT: begin
                        if (is_op) begin
                            v2_nxt    = answer;
                            v1_nxt    = '0;
                            op_nxt    = map_op(key_code);
                            newop_nxt = 1'b1;
                            state_nxt = OP_WAIT;
                        end else if (is_digit) begin
                            // Fresh entry: add to zero so the display follows V1.
                            v2_nxt     = '0;
                            v1_nxt     = {1'b0, {(MAG_W-4){1'b0}}, digit};
                            op_nxt     = 2'b00;
                            newop_nxt  = 1'b1;
                            newhex_nxt = 1'b1;
                            state_nxt  = ENTRY_B;
                        end else if (key_code == K_EQ) begin
                            eq_nxt = 1'b1;
                        end
                    end
                    default: state_nxt = ENTRY_A;
                endcase
            end
        end
    end

    // State, operand and pulse registers; reset clears everything.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state  <= ENTRY_A;
            V1     <= '0;
            V2     <= '0;
            opcode <= 2'b00;
            newop  <= 1'b0;
            newhex <= 1'b0;
            eq     <= 1'b0;
        end else begin
            state  <= state_nxt;
            V1     <= v1_nxt;
            V2     <= v2_nxt;
            opcode <= op_nxt;
            newop  <= newop_nxt;
            newhex <= newhex_nxt;
            eq     <= eq_nxt;
        end
    end

    assign disp_value = (state == RESULT) ? answer : V1;
    assign disp_ovw   = (state == RESULT) && ovw_in;

endmodule

// File: tb/tb_calc_entry_ctrl.sv
// Bench for calc_entry_ctrl: directed key sequences with hand-computed
// expectations pushed to a scoreboard queue; a monitor pops one expectation
// after each clock edge (or asynchronous reset) that has one pending.
module tb_calc_entry_ctrl;

    localparam logic [4:0] K_ADD = 5'h10;
    localparam logic [4:0] K_MUL = 5'h11;
    localparam logic [4:0] K_SUB = 5'h12;
    localparam logic [4:0] K_EQ  = 5'h13;
    localparam logic [4:0] K_CLR = 5'h14;
    localparam logic [4:0] K_NEG = 5'h15;

    logic        clock = 1'b0;
    logic        reset;
    logic        key_valid;
    logic [4:0]  key_code;
    logic [16:0] answer;
    logic        ovw_in;
    logic [16:0] V1, V2, disp_value;
    logic [1:0]  opcode;
    logic        newop, newhex, eq, disp_ovw;
    logic        ovw_force;

    typedef struct packed {
        logic [16:0] v1;
        logic [16:0] v2;
        logic [1:0]  op;
        logic [2:0]  p;     // {newop, newhex, eq}
        logic [16:0] disp;
        logic        dovw;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    errors = 0;
    int    checks = 0;

    calc_entry_ctrl #(.MAG_W(16), .DIGITS(4), .KEY_W(5)) dut (
        .clock      (clock),
        .reset      (reset),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .answer     (answer),
        .ovw_in     (ovw_in),
        .V1         (V1),
        .V2         (V2),
        .opcode     (opcode),
        .newop      (newop),
        .newhex     (newhex),
        .eq         (eq),
        .disp_value (disp_value),
        .disp_ovw   (disp_ovw)
    );

    always #5 clock = ~clock;

    // Stand-in arithmetic module: sign-magnitude V2 op V1, overflow returns 0.
    longint a_m, b_m, r_m, mag_m;
    always_comb begin
        a_m   = V2[16] ? -longint'(V2[15:0]) : longint'(V2[15:0]);
        b_m   = V1[16] ? -longint'(V1[15:0]) : longint'(V1[15:0]);
        r_m   = 0;
        case (opcode)
            2'b01:   r_m = a_m * b_m;
            2'b10:   r_m = a_m - b_m;
            default: r_m = a_m + b_m;
        endcase
        mag_m = (r_m < 0) ? -r_m : r_m;
        if (ovw_force || mag_m > 65535) begin
            answer = 17'h0;
            ovw_in = 1'b1;
        end else begin
            answer = {(r_m < 0), mag_m[15:0]};
            ovw_in = 1'b0;
        end
    end

    task automatic push(input string nm, input logic [16:0] ev1, input logic [16:0] ev2,
                        input logic [1:0] eop, input logic [2:0] ep,
                        input logic [16:0] ed, input logic eo);
        exp_t e;
        e.v1 = ev1; e.v2 = ev2; e.op = eop; e.p = ep; e.disp = ed; e.dovw = eo;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // One clock of stimulus (key or idle) with the state expected after its edge.
    task automatic step(input logic kv, input logic [4:0] c, input string nm,
                        input logic [16:0] ev1, input logic [16:0] ev2,
                        input logic [1:0] eop, input logic [2:0] ep,
                        input logic [16:0] ed, input logic eo);
        @(negedge clock);
        key_valid = kv;
        key_code  = c;
        push(nm, ev1, ev2, eop, ep, ed, eo);
    endtask

    // Change the overflow input only after the pending check has been taken.
    task automatic set_ovw(input logic v);
        @(posedge clock);
        #2;
        ovw_force = v;
    endtask

    // Monitor: compare the DUT against the oldest pending expectation.
    initial begin
        exp_t  act, e;
        string nm;
        forever begin
            @(posedge clock or negedge reset);
            #1;
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                act.v1 = V1; act.v2 = V2; act.op = opcode;
                act.p = {newop, newhex, eq}; act.disp = disp_value; act.dovw = disp_ovw;
                checks++;
                if (act !== e) begin
                    errors++;
                    $display("FAIL %s: got V1=%h V2=%h op=%b pulses=%b disp=%h ovw=%b, want V1=%h V2=%h op=%b pulses=%b disp=%h ovw=%b",
                             nm, act.v1, act.v2, act.op, act.p, act.disp, act.dovw,
                             e.v1, e.v2, e.op, e.p, e.disp, e.dovw);
                end
            end
        end
    end

    initial begin
        reset     = 1'b0;
        key_valid = 1'b0;
        key_code  = 5'h00;
        ovw_force = 1'b1;

        // Reset state, with a key presented while reset is held.
        step(1, 5'h05, "reset_state", 17'h0, 17'h0, 2'b00, 3'b000, 17'h0, 1'b0);
        @(negedge clock);
        key_valid = 1'b0;
        reset     = 1'b1;
        ovw_force = 1'b0;

        // Back-to-back digits; the fifth is dropped.
        step(1, 5'h01, "dig1",  17'h00001, 17'h0, 2'b00, 3'b010, 17'h00001, 1'b0);
        step(1, 5'h02, "dig2",  17'h00012, 17'h0, 2'b00, 3'b010, 17'h00012, 1'b0);
        step(1, 5'h03, "dig3",  17'h00123, 17'h0, 2'b00, 3'b010, 17'h00123, 1'b0);
        step(1, 5'h04, "dig4",  17'h01234, 17'h0, 2'b00, 3'b010, 17'h01234, 1'b0);
        step(1, 5'h05, "dig5_drop", 17'h01234, 17'h0, 2'b00, 3'b000, 17'h01234, 1'b0);
        step(0, 5'h00, "idle_a", 17'h01234, 17'h0, 2'b00, 3'b000, 17'h01234, 1'b0);
        step(1, 5'h16, "unmapped16", 17'h01234, 17'h0, 2'b00, 3'b000, 17'h01234, 1'b0);
        step(1, 5'h1F, "unmapped1F", 17'h01234, 17'h0, 2'b00, 3'b000, 17'h01234, 1'b0);
        step(1, K_EQ,  "eq_in_entry_a", 17'h01234, 17'h0, 2'b00, 3'b000, 17'h01234, 1'b0);
        step(1, K_NEG, "neg_a1", 17'h11234, 17'h0, 2'b00, 3'b010, 17'h11234, 1'b0);
        step(1, K_NEG, "neg_a2", 17'h01234, 17'h0, 2'b00, 3'b010, 17'h01234, 1'b0);
        step(1, K_CLR, "clear_a", 17'h0, 17'h0, 2'b00, 3'b100, 17'h0, 1'b0);

        // 3 add 5 eq, then RESULT behaviours and overflow display.
        step(1, 5'h03, "b_3",    17'h00003, 17'h0, 2'b00, 3'b010, 17'h00003, 1'b0);
        step(1, K_ADD, "b_add",  17'h0, 17'h00003, 2'b00, 3'b100, 17'h0, 1'b0);
        step(1, 5'h05, "b_5",    17'h00005, 17'h00003, 2'b00, 3'b010, 17'h00005, 1'b0);
        step(1, K_EQ,  "b_eq",   17'h00005, 17'h00003, 2'b00, 3'b001, 17'h00008, 1'b0);
        step(0, 5'h00, "b_idle", 17'h00005, 17'h00003, 2'b00, 3'b000, 17'h00008, 1'b0);
        step(1, K_EQ,  "b_eq_again", 17'h00005, 17'h00003, 2'b00, 3'b001, 17'h00008, 1'b0);
        step(1, K_NEG, "b_neg_ignored", 17'h00005, 17'h00003, 2'b00, 3'b000, 17'h00008, 1'b0);
        step(1, 5'h06, "b_fresh_digit", 17'h00006, 17'h0, 2'b00, 3'b110, 17'h00006, 1'b0);
        step(1, K_EQ,  "b_eq2",  17'h00006, 17'h0, 2'b00, 3'b001, 17'h00006, 1'b0);
        set_ovw(1'b1);
        step(0, 5'h00, "b_ovw_shown", 17'h00006, 17'h0, 2'b00, 3'b000, 17'h0, 1'b1);
        step(1, K_ADD, "b_ovw_chain", 17'h0, 17'h0, 2'b00, 3'b100, 17'h0, 1'b0);
        set_ovw(1'b0);
        step(1, K_CLR, "clear_b", 17'h0, 17'h0, 2'b00, 3'b100, 17'h0, 1'b0);

        // 7 sub 2 mul 3 eq -> 15, then operator from RESULT chains the answer.
        step(1, 5'h07, "c_7",   17'h00007, 17'h0, 2'b00, 3'b010, 17'h00007, 1'b0);
        step(1, K_SUB, "c_sub", 17'h0, 17'h00007, 2'b10, 3'b100, 17'h0, 1'b0);
        step(1, 5'h02, "c_2",   17'h00002, 17'h00007, 2'b10, 3'b010, 17'h00002, 1'b0);
        step(1, K_MUL, "c_mul_chain", 17'h0, 17'h00005, 2'b01, 3'b100, 17'h0, 1'b0);
        step(1, 5'h03, "c_3",   17'h00003, 17'h00005, 2'b01, 3'b010, 17'h00003, 1'b0);
        step(1, K_EQ,  "c_eq",  17'h00003, 17'h00005, 2'b01, 3'b001, 17'h0000F, 1'b0);
        step(1, K_SUB, "c_result_op", 17'h0, 17'h0000F, 2'b10, 3'b100, 17'h0, 1'b0);
        step(1, 5'h04, "c_4",   17'h00004, 17'h0000F, 2'b10, 3'b010, 17'h00004, 1'b0);
        step(1, K_EQ,  "c_eq2", 17'h00004, 17'h0000F, 2'b10, 3'b001, 17'h0000B, 1'b0);
        step(1, K_CLR, "clear_c", 17'h0, 17'h0, 2'b00, 3'b100, 17'h0, 1'b0);

        // 4 add mul: operator replaced in OP_WAIT; negative second operand.
        step(1, 5'h04, "d_4",   17'h00004, 17'h0, 2'b00, 3'b010, 17'h00004, 1'b0);
        step(1, K_ADD, "d_add", 17'h0, 17'h00004, 2'b00, 3'b100, 17'h0, 1'b0);
        step(1, K_MUL, "d_mul_replace", 17'h0, 17'h00004, 2'b01, 3'b100, 17'h0, 1'b0);
        step(1, K_NEG, "d_neg_opwait", 17'h10000, 17'h00004, 2'b01, 3'b010, 17'h10000, 1'b0);
        step(1, 5'h02, "d_2",   17'h10002, 17'h00004, 2'b01, 3'b010, 17'h10002, 1'b0);
        step(1, K_EQ,  "d_eq",  17'h10002, 17'h00004, 2'b01, 3'b001, 17'h10008, 1'b0);
        step(1, K_CLR, "clear_d", 17'h0, 17'h0, 2'b00, 3'b100, 17'h0, 1'b0);

        // negate, 9, clear.
        step(1, K_NEG, "e_neg", 17'h10000, 17'h0, 2'b00, 3'b010, 17'h10000, 1'b0);
        step(1, 5'h09, "e_9",   17'h10009, 17'h0, 2'b00, 3'b010, 17'h10009, 1'b0);
        step(1, K_CLR, "e_clear", 17'h0, 17'h0, 2'b00, 3'b100, 17'h0, 1'b0);
        step(1, K_EQ,  "e_eq_ignored", 17'h0, 17'h0, 2'b00, 3'b000, 17'h0, 1'b0);

        // Asynchronous reset in ENTRY_B with V1=0x00123.
        step(1, 5'h01, "f_1",   17'h00001, 17'h0, 2'b00, 3'b010, 17'h00001, 1'b0);
        step(1, K_ADD, "f_add", 17'h0, 17'h00001, 2'b00, 3'b100, 17'h0, 1'b0);
        step(1, 5'h01, "f_b1",  17'h00001, 17'h00001, 2'b00, 3'b010, 17'h00001, 1'b0);
        step(1, 5'h02, "f_b2",  17'h00012, 17'h00001, 2'b00, 3'b010, 17'h00012, 1'b0);
        step(1, 5'h03, "f_b3",  17'h00123, 17'h00001, 2'b00, 3'b010, 17'h00123, 1'b0);
        @(negedge clock);
        key_valid = 1'b0;
        #2;
        push("f_async_reset", 17'h0, 17'h0, 2'b00, 3'b000, 17'h0, 1'b0);
        reset = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        step(1, K_EQ,  "f_eq_after_reset", 17'h0, 17'h0, 2'b00, 3'b000, 17'h0, 1'b0);
        step(1, 5'h07, "f_digit_after_reset", 17'h00007, 17'h0, 2'b00, 3'b010, 17'h00007, 1'b0);
        step(0, 5'h00, "f_idle", 17'h00007, 17'h0, 2'b00, 3'b000, 17'h00007, 1'b0);

        // Drain the scoreboard within a bounded number of cycles.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clock);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
